inst_decode_stage: RTL and testbench

//  Pipeline stage between instruction fetch and the immediate generator / register file.
//  - Accepts 32-bit instructions plus PC over a valid/ready handshake.
//  - Pre-decodes the opcode into imm_type and register indices.
//  - Buffers them in a 2-entry skid buffer.
//  - Presents inst[31:7] and imm_type to the immediate generator with full backpressure and flush support.

---
 rtl/inst_decode_stage.sv | 92 +++++++++
 tb/tb_inst_decode_stage.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/inst_decode_stage.sv
// inst_decode_stage: pre-decodes fetched instructions and buffers them in a 2-entry skid buffer for the immediate generator
module inst_decode_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] PC_RESET = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst_in,
    input  logic [XLEN-1:0] pc_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [25:0]     inst_out,
    output logic [2:0]      imm_type_out,
    output logic [4:0]      rd_out,
    output logic [4:0]      rs1_out,
    output logic [4:0]      rs2_out,
    output logic [XLEN-1:0] pc_out,
    output logic            illegal_out,
    output logic [XLEN-1:0] dec_count
);
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            ill;
        logic [2:0]      ty;
        logic [24:0]     ins;
    } entry_t;

    entry_t          head_q, head_d, skid_q, skid_d, new_e;
    logic            head_v_q, head_v_d, skid_v_q, skid_v_d;
    logic [XLEN-1:0] cnt_q, cnt_d;
    logic [2:0]      ty;
    logic            ill, acc, xfer;

    // Opcode pre-decode; a non-11 low pair never matches a listed opcode, so it lands in default
    always_comb begin
        ty  = 3'b111;
        ill = 1'b0;
        case (inst_in[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: ty = 3'b000;
            7'b0100011:                                     ty = 3'b001;
            7'b1100011:                                     ty = 3'b010;
            7'b0110111, 7'b0010111:                         ty = 3'b011;
            7'b1101111:                                     ty = 3'b100;
            7'b0110011:                                     ty = 3'b111;
            default:                                        ill = 1'b1;
        endcase
    end

    assign new_e = '{pc: pc_in, ill: ill, ty: ty, ins: inst_in[31:7]};

    // Head/skid next state: skid refills head on transfer, new entries fill the first free slot
    always_comb begin
        acc      = in_valid & ~skid_v_q;
        xfer     = head_v_q & out_ready;
        head_d   = (skid_v_q & xfer) ? skid_q : ((acc & (~head_v_q | xfer)) ? new_e : head_q);
        skid_d   = (acc & head_v_q & ~xfer) ? new_e : skid_q;
        head_v_d = ~flush & ((head_v_q & ~xfer) | skid_v_q | acc);
        skid_v_d = ~flush & ((skid_v_q & ~xfer) | (acc & head_v_q & ~xfer));
        cnt_d    = cnt_q + XLEN'(xfer);
    end

    // State registers; reset wins over flush and handshakes
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q   <= entry_t'{pc: PC_RESET, ill: 1'b0, ty: 3'b000, ins: 25'b0};
            skid_q   <= '0;
            head_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            head_q   <= head_d;
            skid_q   <= skid_d;
            head_v_q <= head_v_d;
            skid_v_q <= skid_v_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready     = ~skid_v_q;
    assign out_valid    = head_v_q;
    assign inst_out     = {1'b0, head_q.ins};
    assign imm_type_out = head_q.ty;
    assign rd_out       = head_q.ins[4:0];
    assign rs1_out      = head_q.ins[12:8];
    assign rs2_out      = head_q.ins[17:13];
    assign pc_out       = head_q.pc;
    assign illegal_out  = head_q.ill;
    assign dec_count    = cnt_q;
endmodule

// File: tb/tb_inst_decode_stage.sv
// tb_inst_decode_stage: randomized and directed checks of inst_decode_stage against a queue-based model
module tb_inst_decode_stage;
    localparam int         XLEN     = 8;
    localparam logic [7:0] PC_RESET = 8'hA5;

    logic        clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
    logic [31:0] inst_in = 0;
    logic [7:0]  pc_in = 0;
    logic        in_ready, out_valid, illegal_out;
    logic [25:0] inst_out;
    logic [2:0]  imm_type_out;
    logic [4:0]  rd_out, rs1_out, rs2_out;
    logic [7:0]  pc_out, dec_count;

    int vectors = 0, miscompares = 0;

    inst_decode_stage #(.XLEN(XLEN), .PC_RESET(PC_RESET)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .inst_in(inst_in), .pc_in(pc_in), .out_valid(out_valid), .out_ready(out_ready),
        .inst_out(inst_out), .imm_type_out(imm_type_out), .rd_out(rd_out), .rs1_out(rs1_out),
        .rs2_out(rs2_out), .pc_out(pc_out), .illegal_out(illegal_out), .dec_count(dec_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [7:0]  pc;
    } ent_t;

    ent_t       q[$];
    logic [7:0] cnt = 0;

    // {illegal, imm_type} from the opcode table
    function automatic logic [3:0] exp_dec(input logic [31:0] i);
        if (i[1:0] != 2'b11) return 4'b1111;
        case (i[6:0])
            7'h03, 7'h13, 7'h67, 7'h73: return 4'b0000;
            7'h23:                      return 4'b0001;
            7'h63:                      return 4'b0010;
            7'h37, 7'h17:               return 4'b0011;
            7'h6F:                      return 4'b0100;
            7'h33:                      return 4'b0111;
            default:                    return 4'b1111;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a FIFO of at most two entries; pop on transfer, then flush or push
    always @(posedge clk) begin
        bit rdy, xf;
        if (rst) begin
            q.delete();
            cnt = 0;
        end else begin
            rdy = q.size() < 2;
            xf  = q.size() > 0 && out_ready;
            if (xf) begin
                void'(q.pop_front());
                cnt = cnt + 8'd1;
            end
            if (flush) q.delete();
            else if (in_valid && rdy) q.push_back('{inst_in, pc_in});
        end
    end

    // Compare DUT outputs to the model every cycle
    always @(negedge clk) begin
        logic [3:0] d;
        chk("out_valid", out_valid, q.size() > 0);
        chk("in_ready", in_ready, q.size() < 2);
        chk("dec_count", dec_count, cnt);
        if (q.size() > 0) begin
            d = exp_dec(q[0].inst);
            chk("inst_out", inst_out, {1'b0, q[0].inst[31:7]});
            chk("imm_type", imm_type_out, d[2:0]);
            chk("illegal", illegal_out, d[3]);
            chk("rd", rd_out, q[0].inst[11:7]);
            chk("rs1", rs1_out, q[0].inst[19:15]);
            chk("rs2", rs2_out, q[0].inst[24:20]);
            chk("pc_out", pc_out, q[0].pc);
        end
    end

    task automatic step(input logic iv, input logic [31:0] ins, input logic ordy,
                        input logic fl = 0, input logic r = 0);
        in_valid  = iv;
        inst_in   = ins;
        pc_in     = 8'($urandom);
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        @(negedge clk);
    endtask

    logic [6:0] ops [11] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};

    initial begin
        logic [31:0] r32;
        @(negedge clk);
        step(0, 0, 0, 0, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_pc", pc_out, PC_RESET);
        chk("rst_inst", inst_out, 0);
        chk("rst_type", imm_type_out, 0);
        chk("rst_count", dec_count, 0);
        // T1 pass-through
        step(1, 32'h00500093, 1);
        chk("t1_valid", out_valid, 1);
        chk("t1_type", imm_type_out, 3'b000);
        chk("t1_rd", rd_out, 5'd1);
        chk("t1_rs1", rs1_out, 5'd0);
        chk("t1_ill", illegal_out, 0);
        step(0, 0, 1);
        chk("t1_count", dec_count, 1);
        chk("t1_empty", out_valid, 0);
        // T2 backpressure
        step(1, 32'h00112023, 0);
        step(1, 32'h00000463, 0);
        chk("t2_head", imm_type_out, 3'b001);
        chk("t2_full", in_ready, 0);
        step(0, 0, 1);
        chk("t2_second", imm_type_out, 3'b010);
        chk("t2_ready", in_ready, 1);
        step(0, 0, 1);
        chk("t2_drained", out_valid, 0);
        chk("t2_count", dec_count, 3);
        // T3 accept attempt while full with simultaneous transfer
        step(1, 32'h00112023, 0);
        step(1, 32'h00000463, 0);
        step(1, 32'h123450B7, 1);
        chk("t3_head", imm_type_out, 3'b010);
        chk("t3_ready", in_ready, 1);
        step(0, 0, 1);
        chk("t3_no_lui", out_valid, 0);
        // T4 flush drops buffered entries and the concurrent accept
        step(1, 32'h00112023, 0);
        step(1, 32'h00000463, 0);
        step(1, 32'h123450B7, 0, 1);
        chk("t4_valid", out_valid, 0);
        chk("t4_ready", in_ready, 1);
        // T5 illegal encodings
        step(1, 32'h0000007F, 1);
        chk("t5_type", imm_type_out, 3'b111);
        chk("t5_ill", illegal_out, 1);
        step(1, 32'h00000010, 1);
        chk("t5_lowbits_ill", illegal_out, 1);
        step(1, 32'h00000033, 1);
        chk("t5_op_legal", illegal_out, 0);
        chk("t5_op_type", imm_type_out, 3'b111);
        step(0, 0, 1);
        // T6 reset mid-stall
        step(1, 32'h00112023, 0);
        step(1, 32'h00000463, 0);
        step(1, 32'h00000463, 1, 1, 1);
        chk("t6_valid", out_valid, 0);
        chk("t6_count", dec_count, 0);
        chk("t6_pc", pc_out, PC_RESET);
        // Random traffic; 8-bit counter wraps many times
        for (int i = 0; i < 4000; i++) begin
            r32 = $urandom;
            if ($urandom_range(0, 9) != 0) r32[6:0] = ops[$urandom_range(0, 10)];
            step($urandom_range(0, 3) != 0, r32, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 24) == 0, $urandom_range(0, 299) == 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
